// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator and pwm_capture.
// pwm_capture uses the optional macro PWM_CAPTURE_FILTER_EN.
package pwm_pkg;

    localparam int PWM_W = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // 2-of-3 vote used by the optional glitch filter
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input and measurement results of pwm_capture.
// The master side drives pwm_in and observes the results; the slave side is the capture block.
interface pwm_capture_if;
    import pwm_pkg::*;

    logic             pwm_in;
    logic [PWM_W-1:0] period;
    logic [PWM_W-1:0] duty_cycle;
    logic             valid;
    logic             no_signal;
    logic             level;

    modport master (
        output pwm_in,
        input  period,
        input  duty_cycle,
        input  valid,
        input  no_signal,
        input  level
    );

    modport slave (
        input  pwm_in,
        output period,
        output duty_cycle,
        output valid,
        output no_signal,
        output level
    );

endinterface

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: 2-flop synchronizer, optional 3-sample majority filter
// (enabled by defining PWM_CAPTURE_FILTER_EN) and rising-edge detector.
// Every flop resets to 1, so an input that is already high when reset is
// released does not produce a false rising edge.
module pwm_sync_edge
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_dly;
    logic w_level;

    // Two-stage synchronizer into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic r_tap1;
    logic r_tap2;
    logic r_filt;

    // Vote over three consecutive samples, registered; a clean edge is delayed by 2 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap1 <= 1'b1;
            r_tap2 <= 1'b1;
            r_filt <= 1'b1;
        end else begin
            r_tap1 <= r_sync2;
            r_tap2 <= r_tap1;
            r_filt <= maj3(r_sync2, r_tap1, r_tap2);
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    // Delayed copy of the level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= 1'b1;
        end else begin
            r_dly <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_dly;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input,
// in clk cycles, rising edge to rising edge. Optional input glitch filter
// via PWM_CAPTURE_FILTER_EN (see pwm_sync_edge).
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int TIMEOUT = 16'hFFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_capture_if.slave bus
);

    localparam logic [PWM_W-1:0] TIMEOUT_CNT = PWM_W'(TIMEOUT);
    localparam logic [PWM_W-1:0] ONE         = PWM_W'(1);

    logic             w_level;
    logic             w_rise;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] w_cnt_nxt;
    logic [PWM_W-1:0] r_hcnt;
    logic [PWM_W-1:0] w_hcnt_nxt;
    logic [PWM_W-1:0] r_period;
    logic [PWM_W-1:0] w_period_nxt;
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] w_duty_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_no_signal;
    logic             w_no_signal_nxt;

    pwm_sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pwm   (bus.pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise)
    );

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_duty      <= '0;
            r_valid     <= 1'b0;
            r_no_signal <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_period    <= w_period_nxt;
            r_duty      <= w_duty_nxt;
            r_valid     <= w_valid_nxt;
            r_no_signal <= w_no_signal_nxt;
        end
    end

    // Next state: an edge always wins over the timeout in the same cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hcnt_nxt      = r_hcnt;
        w_period_nxt    = r_period;
        w_duty_nxt      = r_duty;
        w_valid_nxt     = 1'b0;
        w_no_signal_nxt = r_no_signal;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = MEASURE;
                    w_cnt_nxt   = ONE;
                    w_hcnt_nxt  = ONE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_period_nxt    = r_cnt;
                    w_duty_nxt      = r_hcnt;
                    w_valid_nxt     = 1'b1;
                    w_no_signal_nxt = 1'b0;
                    w_cnt_nxt       = ONE;
                    w_hcnt_nxt      = ONE;
                end else if (r_cnt == TIMEOUT_CNT) begin
                    w_state_nxt     = IDLE;
                    w_no_signal_nxt = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + ONE;
                    w_hcnt_nxt = r_hcnt + {{(PWM_W-1){1'b0}}, w_level};
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.period     = r_period;
    assign bus.duty_cycle = r_duty;
    assign bus.valid      = r_valid;
    assign bus.no_signal  = r_no_signal;
    assign bus.level      = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture with a scoreboard of expected
// period/duty pairs. Works with or without PWM_CAPTURE_FILTER_EN.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int TO = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pwm_capture_if bus ();

    pwm_capture #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] sb[$];
    logic        have_prev = 1'b0;
    logic [15:0] prev_p = '0;
    logic [15:0] prev_d = '0;

    // Monitor: every valid pulse is checked against the scoreboard and the pulse spacing
    int          cyc = 0;
    logic        last_ok = 1'b0;
    int          last_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] exp_pd;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            last_ok = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (bus.valid) begin
                checks++;
                assert (sb.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_valid period=%0d duty=%0d required=no valid", bus.period, bus.duty_cycle);
                end
                if (sb.size() > 0) begin
                    exp_pd = sb.pop_front();
                    checks++;
                    assert ({bus.period, bus.duty_cycle} === exp_pd) else begin
                        failures++;
                        $error("FAIL measure got=%0d/%0d exp=%0d/%0d", bus.period, bus.duty_cycle, exp_pd[31:16], exp_pd[15:0]);
                    end
                end
                checks++;
                assert (bus.no_signal === 1'b0) else begin
                    failures++;
                    $error("FAIL no_signal_at_valid got=%b exp=0", bus.no_signal);
                end
                checks++;
                assert (prev_valid === 1'b0) else begin
                    failures++;
                    $error("FAIL valid_width got=2+ cycles exp=1 cycle");
                end
                if (last_ok) begin
                    checks++;
                    assert ((cyc - last_cyc) == int'(bus.period)) else begin
                        failures++;
                        $error("FAIL valid_spacing got=%0d exp=%0d", cyc - last_cyc, bus.period);
                    end
                end
                last_ok = 1'b1;
                last_cyc = cyc;
            end else if (bus.no_signal) begin
                last_ok = 1'b0;
            end
            prev_valid = bus.valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clean period starting with a rising edge; queues the period this edge closes
    task automatic drive(input int p, input int d);
        if (have_prev) sb.push_back({prev_p, prev_d});
        bus.pwm_in = 1'b1;
        repeat (d) tick();
        bus.pwm_in = 1'b0;
        repeat (p - d) tick();
        prev_p = 16'(p);
        prev_d = 16'(d);
        have_prev = 1'b1;
    endtask

    // P=20/D=10 with a 1-cycle low dropout 5 cycles into the high phase
    task automatic drive_glitch();
        if (have_prev) sb.push_back({prev_p, prev_d});
        bus.pwm_in = 1'b1;
        repeat (5) tick();
        bus.pwm_in = 1'b0;
        tick();
`ifndef PWM_CAPTURE_FILTER_EN
        sb.push_back({16'd6, 16'd5});
`endif
        bus.pwm_in = 1'b1;
        repeat (4) tick();
        bus.pwm_in = 1'b0;
        repeat (10) tick();
`ifdef PWM_CAPTURE_FILTER_EN
        prev_p = 16'd20;
        prev_d = 16'd10;
`else
        prev_p = 16'd14;
        prev_d = 16'd4;
`endif
        have_prev = 1'b1;
    endtask

    // Final rising edge: closes the current measurement, then the line is left alone
    task automatic final_rise();
        if (have_prev) sb.push_back({prev_p, prev_d});
        bus.pwm_in = 1'b1;
        have_prev = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        bus.pwm_in = 1'b1;
        #12;
        chk("rst_period", 32'(bus.period), 32'd0);
        chk("rst_duty", 32'(bus.duty_cycle), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_no_signal", 32'(bus.no_signal), 32'd1);
        chk("rst_level", 32'(bus.level), 32'd1);
        tick();
        rst_n = 1'b1;

        // Input high through reset release: no edge, no measurement
        repeat (20) tick();
        chk("hold_high_no_signal", 32'(bus.no_signal), 32'd1);
        bus.pwm_in = 1'b0;
        repeat (5) tick();

        // Loopback 10/3
        repeat (6) drive(10, 3);
        chk("lock_no_signal", 32'(bus.no_signal), 32'd0);

        // Period change to 25/20
        repeat (3) drive(25, 20);

        // Stuck high after lock
        repeat (3) drive(10, 3);
        final_rise();
        repeat (45) tick();
        chk("pre_timeout_no_signal", 32'(bus.no_signal), 32'd0);
        repeat (15) tick();
        chk("to_high_no_signal", 32'(bus.no_signal), 32'd1);
        chk("to_high_level", 32'(bus.level), 32'd1);
        chk("to_high_hold", {bus.period, bus.duty_cycle}, {16'd10, 16'd3});
        bus.pwm_in = 1'b0;
        repeat (10) tick();

        // Stuck low after relock
        repeat (4) drive(10, 3);
        final_rise();
        repeat (3) tick();
        bus.pwm_in = 1'b0;
        repeat (60) tick();
        chk("to_low_no_signal", 32'(bus.no_signal), 32'd1);
        chk("to_low_level", 32'(bus.level), 32'd0);
        chk("to_low_hold", {bus.period, bus.duty_cycle}, {16'd10, 16'd3});

        // Glitch inside the high phase
        repeat (2) drive(20, 10);
        repeat (3) drive_glitch();
        drive(20, 10);

        // Boundary: period equal to TIMEOUT
        repeat (4) drive(TO, 20);
        final_rise();
        repeat (8) tick();
        chk("boundary_no_signal", 32'(bus.no_signal), 32'd0);
        bus.pwm_in = 1'b0;
        repeat (60) tick();

        // Reset in the middle of a period
        repeat (3) drive(10, 3);
        if (have_prev) sb.push_back({prev_p, prev_d});
        bus.pwm_in = 1'b1;
        repeat (3) tick();
        bus.pwm_in = 1'b0;
        repeat (5) tick();
        chk("pre_reset_period", 32'(bus.period), 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_period", 32'(bus.period), 32'd0);
        chk("mid_rst_duty", 32'(bus.duty_cycle), 32'd0);
        chk("mid_rst_valid", 32'(bus.valid), 32'd0);
        chk("mid_rst_no_signal", 32'(bus.no_signal), 32'd1);
        chk("mid_rst_level", 32'(bus.level), 32'd1);
        have_prev = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // After reset the first edge only arms; the second yields 10/3 again
        repeat (3) drive(10, 3);
        final_rise();
        repeat (8) tick();
        bus.pwm_in = 1'b0;
        repeat (5) tick();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
